// File: rtl/branch_predict_ctrl_if.sv
// Fetch/EX <-> branch redirect controller signal bundle.
// BRPRED_STATS_EN adds the statistics counter outputs.
interface branch_predict_ctrl_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] if_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic            ex_is_cond;
    logic [PC_W-1:0] ex_pc;
    logic            ex_pred;
    logic            ex_taken;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] ex_fallthru;
    logic            flush;
    logic            stall_ex;
    logic            redir_valid;
    logic [PC_W-1:0] redir_pc;
    logic            redir_ready;
`ifdef BRPRED_STATS_EN
    logic [15:0]     stat_branches;
    logic [15:0]     stat_mispred;
`endif

    // Pipeline side: drives lookups, resolutions and fetch acceptance.
    modport master (
`ifdef BRPRED_STATS_EN
        input  stat_branches, stat_mispred,
`endif
        output if_pc, ex_valid, ex_is_cond, ex_pc, ex_pred, ex_taken,
        output ex_target, ex_fallthru, redir_ready,
        input  pred_taken, flush, stall_ex, redir_valid, redir_pc
    );

    // Controller side.
    modport slave (
`ifdef BRPRED_STATS_EN
        output stat_branches, stat_mispred,
`endif
        input  if_pc, ex_valid, ex_is_cond, ex_pc, ex_pred, ex_taken,
        input  ex_target, ex_fallthru, redir_ready,
        output pred_taken, flush, stall_ex, redir_valid, redir_pc
    );
endinterface

// File: rtl/branch_predict_ctrl.sv
// 2-bit saturating-counter branch predictor with mispredict flush/redirect FSM.
// Optional BRPRED_STATS_EN adds branch and mispredict statistics counters.
module branch_predict_ctrl #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 4
) (
    input logic                  clk,
    input logic                  rst,
    branch_predict_ctrl_if.slave bus
);
    localparam int unsigned N_CTR = 1 << IDX_W;

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_ctr [N_CTR];
    logic [PC_W-1:0] r_redir_pc;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_mis;
    logic             w_train;
    logic             w_capture;
    logic             w_flush;
    logic             w_stall;
    logic             w_rvalid;
    logic             w_unused;

    assign w_if_idx = bus.if_pc[IDX_W:1];
    assign w_ex_idx = bus.ex_pc[IDX_W:1];
    assign w_mis    = bus.ex_valid && (bus.ex_taken != bus.ex_pred);
    assign w_unused = &{1'b0, bus.if_pc[0], bus.ex_pc[0],
                        bus.if_pc[PC_W-1:IDX_W+1], bus.ex_pc[PC_W-1:IDX_W+1]};

    always_comb begin
        w_state_nxt = r_state;
        w_flush     = 1'b0;
        w_stall     = 1'b0;
        w_rvalid    = 1'b0;
        w_train     = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            IDLE: begin
                w_train = bus.ex_valid && bus.ex_is_cond;
                if (w_mis) begin
                    w_flush     = 1'b1;
                    w_capture   = 1'b1;
                    w_state_nxt = REDIRECT;
                end
            end
            REDIRECT: begin
                w_flush  = 1'b1;
                w_stall  = 1'b1;
                w_rvalid = 1'b1;
                if (bus.redir_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_redir_pc <= '0;
            for (int unsigned i = 0; i < N_CTR; i++) begin
                r_ctr[i] <= 2'b01;
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_redir_pc <= bus.ex_taken ? bus.ex_target : bus.ex_fallthru;
            end
            // Lookup reads the pre-update counter; no bypass on same-index update.
            if (w_train) begin
                if (bus.ex_taken && (r_ctr[w_ex_idx] != 2'b11)) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
                end else if (!bus.ex_taken && (r_ctr[w_ex_idx] != 2'b00)) begin
                    r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
                end
            end
        end
    end

    assign bus.pred_taken  = r_ctr[w_if_idx][1];
    assign bus.flush       = w_flush;
    assign bus.stall_ex    = w_stall;
    assign bus.redir_valid = w_rvalid;
    assign bus.redir_pc    = r_redir_pc;

`ifdef BRPRED_STATS_EN
    logic [15:0] r_stat_br;
    logic [15:0] r_stat_mis;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_br  <= '0;
            r_stat_mis <= '0;
        end else begin
            if (w_train) begin
                r_stat_br <= r_stat_br + 16'd1;
            end
            if (w_capture) begin
                r_stat_mis <= r_stat_mis + 16'd1;
            end
        end
    end

    assign bus.stat_branches = r_stat_br;
    assign bus.stat_mispred  = r_stat_mis;
`endif
endmodule

// File: doc/branch_predict_ctrl.md
Name: branch_predict_ctrl

Overview:
Fetch-redirect controller and dynamic predictor for the branch datapath. Fetch looks up a table of 2-bit saturating counters to get a taken/not-taken prediction. The prediction travels down the pipe and is compared in EX against the resolved branch condition (brchcnd). On a mismatch the block flushes the younger stages, stalls EX and holds a redirect PC until fetch accepts it with a valid/ready handshake. Counters are trained on every resolved conditional branch.

Parameters:
PC_W, 16, PC and target width
IDX_W, 4, table index width; table holds 2^IDX_W counters, index = pc[IDX_W:1] (16-bit instructions, bit 0 ignored)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
if_pc  in  PC_W  fetch-stage PC for lookup
pred_taken  out  1  MSB of counter at if_pc index (combinational)
ex_valid  in  1  EX holds a resolving control-flow instruction (cond branch or jump)
ex_is_cond  in  1  1 = conditional branch (BEQZ/BNEZ/BLTZ/BGEZ), 0 = unconditional jump
ex_pc  in  PC_W  PC of the EX instruction
ex_pred  in  1  prediction carried from fetch
ex_taken  in  1  resolved outcome (brchcnd)
ex_target  in  PC_W  taken target
ex_fallthru  in  PC_W  PC+2
flush  out  1  squash IF/ID and ID/EX
stall_ex  out  1  hold EX and earlier stages
redir_valid  out  1  redirect PC valid
redir_pc  out  PC_W  redirect address
redir_ready  in  1  fetch accepts redirect

Behaviour:
- Reset (sync, active-high):
  - All counters = 2'b01 (weakly not-taken); state = IDLE.
  - redir_valid = 0, redir_pc = 0, flush = 0, stall_ex = 0 in the cycle after rst is sampled.
  - Table is flops, cleared in one cycle.
- Lookup: pred_taken = counter[if_pc[IDX_W:1]][1], pure combinational, no registered latency.
- Mispredict: mis = ex_valid && (ex_taken != ex_pred). A jump with ex_pred = 0 mispredicts (ex_taken is 1 for jumps).
- FSM states: IDLE, REDIRECT.
  - IDLE, mis = 1:
    - flush = 1 combinationally in the same cycle.
    - redir_pc <= ex_taken ? ex_target : ex_fallthru.
    - Next state REDIRECT.
  - IDLE, mis = 0: stay in IDLE; flush = 0, stall_ex = 0.
  - REDIRECT:
    - redir_valid = 1, stall_ex = 1, flush = 1.
    - redir_pc is held stable.
    - ex_* inputs are ignored: no new mispredict detection, no training.
  - REDIRECT, redir_ready = 1: handshake completes this cycle; next state IDLE, redir_valid = 0 next cycle.
  - REDIRECT, redir_ready = 0: hold all outputs unchanged, indefinitely.
- Redirect latency: mispredict in EX at cycle N -> redir_valid first high at N+1. Minimum 1 cycle in REDIRECT.
- Training:
  - Only in IDLE, only when ex_valid && ex_is_cond.
  - counter[ex_pc[IDX_W:1]] increments (saturate at 11) if ex_taken, else decrements (saturate at 00).
  - Training happens in the mispredict cycle too.
  - Jumps never train.
- Same-cycle lookup and update of one index: lookup returns the pre-update value; no bypass.
- rst during REDIRECT overrides everything: IDLE, redir_valid = 0, counters reinitialised next cycle.
- Aliasing: PCs with equal index share a counter. No tags.

Optional Feature:
BRPRED_STATS_EN
- Defined:
  - Adds outputs stat_branches[15:0] and stat_mispred[15:0].
  - stat_branches increments on each IDLE-cycle ex_valid && ex_is_cond.
  - stat_mispred increments on each IDLE-cycle mis (conditional or jump).
  - Both wrap at 16'hFFFF -> 0 and are cleared by rst.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then sweep if_pc 0x0000..0x001E step 2 -> pred_taken = 0 at every index; redir_valid = 0, flush = 0.
- Cond branch ex_pc = 0x0010, ex_pred = 0, ex_taken = 1, target 0x0040, redir_ready = 1:
  - flush = 1 that cycle.
  - Next cycle redir_valid = 1, redir_pc = 0x0040, stall_ex = 1.
  - Following cycle IDLE.
  - if_pc = 0x0010 -> pred_taken = 1 (counter 10).
- Same branch resolved taken 3 more times with matching pred -> counter 11, no flush. Then one not-taken with pred = 1:
  - redirect to fallthru 0x0012.
  - Counter 10, pred_taken still 1.
- Mispredict with redir_ready held 0 for 3 cycles -> redir_valid, stall_ex, flush high 3 cycles, redir_pc stable. ready = 1 on cycle 4 -> IDLE next cycle.
- Jump ex_is_cond = 0, ex_pred = 0, ex_taken = 1, target 0x0100 -> redirect 0x0100; counter at ex_pc index unchanged.
- Assert rst in second REDIRECT cycle -> next cycle redir_valid = 0, stall_ex = 0, and all counters 01. With BRPRED_STATS_EN, stat_branches = stat_mispred = 0.
